// File: rtl/led_mode_ctrl_pkg.sv
// Shared LED mode encodings and default timing constants for the LED mode controller.
// Imported by the controller, its press classifier and any status display logic.
package led_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_ON         = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_e;

    localparam int DEF_SLOW_HALF  = 50;
    localparam int DEF_FAST_HALF  = 12;
    localparam int DEF_LONG_PRESS = 100;
    localparam int DEF_CNT_W      = 7;

    // Short-press advance order; the 2-bit encoding wraps BLINK_FAST back to OFF.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_mode_ctrl_press_classifier.sv
// Classifies debounced presses into short/long events; outputs are combinational 1-clk pulses
// valid on the edge that samples the release (short) or the LONG_PRESS-th high tick (long).
module led_mode_ctrl_press_classifier #(
    parameter int LONG_PRESS = 100,
    parameter int CNT_W      = 7
) (
    input  logic clk_100Hz,
    input  logic rst_n,
    input  logic pb_i,
    output logic short_evt_o,
    output logic long_evt_o
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_PRESS);
    localparam logic [CNT_W-1:0] HOLD_CMP = CNT_W'(LONG_PRESS - 1);

    logic             pb_d_q;
    logic             armed_q;
    logic             long_flag_q, long_flag_d;
    logic             seen_rise_q, seen_rise_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             rise, fall;

    // armed_q blocks the artificial rise seen when pb is already high as reset releases.
    assign rise = pb_i & ~pb_d_q & armed_q;
    assign fall = ~pb_i & pb_d_q;

    assign long_evt_o  = pb_i && (hold_cnt_q == HOLD_CMP);
    assign short_evt_o = fall & ~long_flag_q & seen_rise_q;

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        seen_rise_d = seen_rise_q;
        if (!pb_i) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (fall) begin
            long_flag_d = 1'b0;
            seen_rise_d = 1'b0;
        end else begin
            if (long_evt_o) long_flag_d = 1'b1;
            if (rise)       seen_rise_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            pb_d_q      <= 1'b0;
            armed_q     <= 1'b0;
            long_flag_q <= 1'b0;
            seen_rise_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            pb_d_q      <= pb_i;
            armed_q     <= 1'b1;
            long_flag_q <= long_flag_d;
            seen_rise_q <= seen_rise_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode register and blinker driven by short/long press events from the classifier.
// Mode and LED are registered; mode changes one clk after release sampled, or at long-press tick.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int SLOW_HALF  = DEF_SLOW_HALF,
    parameter int FAST_HALF  = DEF_FAST_HALF,
    parameter int LONG_PRESS = DEF_LONG_PRESS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk_100Hz,
    input  logic       rst_n,
    input  logic       pb,
    output logic       led,
    output logic [1:0] mode
);

    localparam logic [CNT_W-1:0] SLOW_CMP = CNT_W'(SLOW_HALF - 1);
    localparam logic [CNT_W-1:0] FAST_CMP = CNT_W'(FAST_HALF - 1);

    mode_e            mode_q, mode_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0] half_cmp;
    logic             short_evt, long_evt;

    led_mode_ctrl_press_classifier #(
        .LONG_PRESS (LONG_PRESS),
        .CNT_W      (CNT_W)
    ) u_press_classifier (
        .clk_100Hz   (clk_100Hz),
        .rst_n       (rst_n),
        .pb_i        (pb),
        .short_evt_o (short_evt),
        .long_evt_o  (long_evt)
    );

    // LED logic keys off the next mode so a long press forcing OFF beats a blink toggle.
    always_comb begin
        mode_d      = mode_q;
        led_d       = led_q;
        blink_cnt_d = blink_cnt_q;
        half_cmp    = (mode_d == MODE_BLINK_SLOW) ? SLOW_CMP : FAST_CMP;
        if (long_evt) begin
            mode_d = MODE_OFF;
        end else if (short_evt) begin
            mode_d = next_mode(mode_q);
        end
        half_cmp = (mode_d == MODE_BLINK_SLOW) ? SLOW_CMP : FAST_CMP;
        case (mode_d)
            MODE_OFF: begin
                led_d       = 1'b0;
                blink_cnt_d = '0;
            end
            MODE_ON: begin
                led_d       = 1'b1;
                blink_cnt_d = '0;
            end
            default: begin
                if (mode_d != mode_q) begin
                    led_d       = 1'b1;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == half_cmp) begin
                    led_d       = ~led_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            led_q       <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule
